// File: rtl/cart_dl_streamer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cart_dl_streamer : byte stream -> 16-bit little-endian cart loader writes
// Rev 1.0
// ---------------------------------------------------------------------------
module cart_dl_streamer #(
  parameter int unsigned TAIL_CYCLES = 4,
  parameter logic [7:0]  PAD_BYTE    = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [24:0] len,
  input  logic        abort,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        cart_download,
  output logic        ioctl_wr,
  output logic [24:0] ioctl_addr,
  output logic [15:0] ioctl_dout,
  input  logic        ioctl_wait,
  output logic        busy,
  output logic        done,
  output logic        aborted
);

  localparam int unsigned   TW        = (TAIL_CYCLES > 1) ? $clog2(TAIL_CYCLES) : 1;
  localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LO, S_HI, S_WR, S_GUARD, S_WAIT, S_TAIL
  } state_t;

  state_t        r_state;
  logic [24:0]   r_remaining;
  logic [24:0]   r_addr;
  logic [7:0]    r_lo;
  logic [TW-1:0] r_tail_cnt;
  logic          r_abort_pend;
  logic          r_dl, r_wr, r_busy, r_done, r_aborted;
  logic [24:0]   r_ioctl_addr;
  logic [15:0]   r_ioctl_dout;
  logic          w_fill;

  // Abort wins over a same-cycle byte so the source never loses a byte to a discarded word.
  assign w_fill    = (r_state == S_LO) || (r_state == S_HI);
  assign src_ready = w_fill & ~abort;

  assign cart_download = r_dl;
  assign ioctl_wr      = r_wr;
  assign ioctl_addr    = r_ioctl_addr;
  assign ioctl_dout    = r_ioctl_dout;
  assign busy          = r_busy;
  assign done          = r_done;
  assign aborted       = r_aborted;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_remaining  <= '0;
      r_addr       <= '0;
      r_lo         <= '0;
      r_tail_cnt   <= '0;
      r_abort_pend <= 1'b0;
      r_dl         <= 1'b0;
      r_wr         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_ioctl_addr <= '0;
      r_ioctl_dout <= '0;
    end else begin
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_done) begin
            r_aborted <= 1'b0;
            if (len != '0) begin
              r_remaining  <= len;
              r_addr       <= '0;
              r_abort_pend <= 1'b0;
              r_busy       <= 1'b1;
              r_dl         <= 1'b1;
              r_state      <= S_LO;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_LO: begin
          if (abort) begin
            r_aborted  <= 1'b1;
            r_tail_cnt <= '0;
            r_state    <= S_TAIL;
          end else if (src_valid) begin
            r_remaining <= r_remaining - 25'd1;
            if (r_remaining == 25'd1) begin
              r_ioctl_dout <= {PAD_BYTE, src_data};
              r_ioctl_addr <= r_addr;
              r_wr         <= 1'b1;
              r_state      <= S_WR;
            end else begin
              r_lo    <= src_data;
              r_state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (abort) begin
            r_aborted  <= 1'b1;
            r_tail_cnt <= '0;
            r_state    <= S_TAIL;
          end else if (src_valid) begin
            r_remaining  <= r_remaining - 25'd1;
            r_ioctl_dout <= {src_data, r_lo};
            r_ioctl_addr <= r_addr;
            r_wr         <= 1'b1;
            r_state      <= S_WR;
          end
        end
        S_WR: begin
          r_abort_pend <= abort;
          r_state      <= S_GUARD;
        end
        S_GUARD: begin
          r_abort_pend <= r_abort_pend | abort;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_abort_pend <= r_abort_pend | abort;
          if (!ioctl_wait) begin
            r_addr <= r_addr + 25'd2;
            if ((r_remaining == '0) || r_abort_pend || abort) begin
              r_aborted  <= r_abort_pend | abort;
              r_tail_cnt <= '0;
              r_state    <= S_TAIL;
            end else begin
              r_state <= S_LO;
            end
          end
        end
        S_TAIL: begin
          if (r_tail_cnt == TAIL_LAST) begin
            r_dl    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tail_cnt <= r_tail_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cart_dl_streamer.sv
`default_nettype none
// tb_cart_dl_streamer : randomized transfers checked against a word-level model
// of the cartridge download stream.
module tb_cart_dl_streamer;

  localparam int         TAIL = 4;
  localparam logic [7:0] PAD  = 8'hFF;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [24:0] len = '0;
  logic        abort = 1'b0;
  logic        src_valid = 1'b0;
  logic [7:0]  src_data = '0;
  logic        ioctl_wait = 1'b0;
  logic        src_ready, cart_download, ioctl_wr, busy, done, aborted;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;

  always #5 clk_sys = ~clk_sys;

  cart_dl_streamer #(.TAIL_CYCLES(TAIL), .PAD_BYTE(PAD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .cart_download(cart_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .busy(busy), .done(done),
    .aborted(aborted)
  );

  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          strobes = 0;
  int          exp_words = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  bit          done_seen = 1'b0;
  logic [7:0]  bytes_mem [0:1023];
  logic [24:0] exp_addr [$];
  logic [15:0] exp_dout [$];
  logic [24:0] cap_addr [0:3];
  logic [15:0] cap_dout [0:3];
  logic [15:0] ref_dout [0:3];
  logic [15:0] hdr_word = '0;
  logic [24:0] held_addr = '0;
  logic [15:0] held_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Per-cycle compare against the expected word stream.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset_n) begin
        chk("dl_vs_busy", cart_download, busy);
        if (!busy) chk("ready_idle", src_ready, 1'b0);
        if (ioctl_wr) begin
          chk("wr_during_wait", ioctl_wait, 1'b0);
          chk("addr_even", ioctl_addr[0], 1'b0);
          if (exp_addr.size() == 0) begin
            chk("extra_strobe", strobes + 1, exp_words);
          end else begin
            chk("word_addr", ioctl_addr, exp_addr.pop_front());
            chk("word_dout", ioctl_dout, exp_dout.pop_front());
          end
          if (strobes < 4) begin
            cap_addr[strobes] = ioctl_addr;
            cap_dout[strobes] = ioctl_dout;
          end
          if (ioctl_addr == 25'h146) hdr_word = ioctl_dout;
          strobes++;
          last_wr_cyc = cyc;
          held_addr = ioctl_addr;
          held_dout = ioctl_dout;
        end
        if (ioctl_wait) begin
          chk("addr_hold", ioctl_addr, held_addr);
          chk("dout_hold", ioctl_dout, held_dout);
        end
        if (done) begin
          done_seen = 1'b1;
          done_cyc  = cyc;
          chk("dl_at_done", cart_download, 1'b0);
        end
      end
    end
  end

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) bytes_mem[i] = 8'($urandom_range(255));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dl"}, cart_download, 1'b0);
    chk({tag, "_wr"}, ioctl_wr, 1'b0);
    chk({tag, "_addr"}, ioctl_addr, 25'd0);
    chk({tag, "_dout"}, ioctl_dout, 16'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_aborted"}, aborted, 1'b0);
    chk({tag, "_ready"}, src_ready, 1'b0);
  endtask

  // vprob: percent chance src_valid is offered, or -1 for strict alternation.
  // abort_at: number of accepted bytes after which abort is pulsed (-1: none).
  task automatic run_xfer(input int n, input int wmin, input int wmax, input int vprob,
                          input int abort_at, input bit poke_start, input bit rst_mid);
    int hs, wait_left, nlast, t, wait_age, nw;
    bit wr_prev, ab_done, ab_exp;
    ab_exp = (abort_at >= 0);
    nw = ab_exp ? abort_at / 2 : (n + 1) / 2;
    exp_words = nw;
    exp_addr.delete();
    exp_dout.delete();
    for (int k = 0; k < nw; k++) begin
      exp_addr.push_back(25'(2 * k));
      exp_dout.push_back({(2 * k + 1 < n) ? bytes_mem[2 * k + 1] : PAD, bytes_mem[2 * k]});
    end
    strobes = 0; done_seen = 1'b0; hs = 0; wait_left = 0; wr_prev = 1'b0;
    ab_done = 1'b0; nlast = 0; wait_age = 0; t = 0;
    @(posedge clk_sys); #1;
    start = 1'b1; len = 25'(n);
    @(posedge clk_sys); #1;
    start = 1'b0;
    while (!done_seen && t < 20000) begin
      if (wr_prev) begin
        wait_left = $urandom_range(wmax, wmin);
        nlast = wait_left;
      end
      ioctl_wait = (wait_left > 0);
      if (wait_left > 0) wait_left--;
      wr_prev  = ioctl_wr;
      wait_age = ioctl_wait ? wait_age + 1 : 0;
      if (rst_mid && strobes == 1 && wait_age == 3) begin
        reset_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        ioctl_wait = 1'b0; src_valid = 1'b0;
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        exp_addr.delete(); exp_dout.delete();
        return;
      end
      src_valid = (hs < n) && ((vprob < 0) ? (t % 2 == 0) : ($urandom_range(99) < vprob));
      src_data  = (hs < n) ? bytes_mem[hs] : 8'h00;
      abort     = ab_exp && !ab_done && (hs == abort_at);
      if (abort) ab_done = 1'b1;
      if (poke_start) begin
        start = (t == 6);
        if (t == 6) len = 25'($urandom_range(50, 1));
      end
      #1;
      if (src_valid && src_ready) hs++;
      @(posedge clk_sys); #1;
      t++;
    end
    start = 1'b0; abort = 1'b0; src_valid = 1'b0; ioctl_wait = 1'b0;
    chk("xfer_done", done_seen, 1'b1);
    chk("strobe_count", strobes, nw);
    chk("handshakes", hs, ab_exp ? abort_at : n);
    chk("aborted_flag", aborted, ab_exp);
    chk("busy_after", busy, 1'b0);
    if (!ab_exp && nw > 0)
      chk("tail_timing", done_cyc - last_wr_cyc, 2 + ((nlast > 1) ? nlast : 1) + TAIL);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(posedge clk_sys); #1;

    for (int i = 0; i < 4; i++) bytes_mem[i] = 8'(i);
    run_xfer(4, 0, 0, 100, -1, 1'b0, 1'b0);
    chk("t4_w0_addr", cap_addr[0], 25'd0);
    chk("t4_w0_dout", cap_dout[0], 16'h0100);
    chk("t4_w1_addr", cap_addr[1], 25'd2);
    chk("t4_w1_dout", cap_dout[1], 16'h0302);

    bytes_mem[0] = 8'hAA; bytes_mem[1] = 8'hBB; bytes_mem[2] = 8'hCC;
    run_xfer(3, 0, 2, 100, -1, 1'b0, 1'b0);
    chk("t3_w0_dout", cap_dout[0], 16'hBBAA);
    chk("t3_w1_addr", cap_addr[1], 25'd2);
    chk("t3_w1_dout", cap_dout[1], 16'hFFCC);

    fill_random(25'h150);
    hdr_word = '0;
    run_xfer(25'h150, 10, 10, 100, -1, 1'b1, 1'b0);
    chk("long_strobes", strobes, 32'hA8);
    chk("hdr_word", hdr_word, {bytes_mem[25'h147], bytes_mem[25'h146]});

    fill_random(6);
    run_xfer(6, 0, 1, 100, -1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) ref_dout[k] = cap_dout[k];
    run_xfer(6, 0, 1, -1, -1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) chk("toggle_same", cap_dout[k], ref_dout[k]);

    fill_random(8);
    run_xfer(8, 0, 2, 100, 3, 1'b0, 1'b0);
    chk("abort_one_wr", strobes, 32'd1);

    exp_words = 0; strobes = 0; exp_addr.delete(); exp_dout.delete();
    @(posedge clk_sys); #1;
    start = 1'b1; len = '0;
    chk("len0_dl_a", cart_download, 1'b0);
    @(posedge clk_sys); #1;
    start = 1'b0;
    chk("len0_done", done, 1'b1);
    chk("len0_dl_b", cart_download, 1'b0);
    chk("len0_busy", busy, 1'b0);
    @(posedge clk_sys); #1;
    chk("len0_done_clr", done, 1'b0);
    chk("len0_no_wr", strobes, 32'd0);

    for (int i = 0; i < 8; i++) begin
      int n;
      n = $urandom_range(40, 1);
      fill_random(n);
      run_xfer(n, 0, 3, $urandom_range(100, 30), -1, 1'b0, 1'b0);
    end

    fill_random(20);
    run_xfer(20, 10, 10, 100, -1, 1'b0, 1'b1);
    fill_random(5);
    run_xfer(5, 0, 2, 80, -1, 1'b0, 1'b0);

    repeat (2) @(posedge clk_sys);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
